// File: rtl/key_debounce_bank_pkg.sv
// Shared definitions for the key debouncer bank: per-channel FSM states
// and the stability window lengths used in simulation and on the board.
package key_debounce_bank_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,  // committed level 0
    CHK_HI  = 2'd1,  // candidate level 1 being qualified
    IDLE_HI = 2'd2,  // committed level 1
    CHK_LO  = 2'd3   // candidate level 0 being qualified
  } db_state_e;

  localparam int unsigned STABLE_CYCLES_SIM = 4;
  localparam int unsigned STABLE_CYCLES_SYN = 4194304;

endpackage

// File: rtl/key_debounce_bank_channel.sv
// Single-bit debouncer: synchroniser, qualification FSM, stability counter,
// and registered level / press / release outputs.
module debounce_channel
  import key_debounce_bank_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_SYN,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic KEY_IN,
  input  logic EN,
  output logic KEY_OUT,
  output logic PRESS,
  output logic RELEASE
);

  localparam int unsigned       CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   key_d, press_d, release_d;

  assign s = sync_q[SYNC_STAGES-1];

  // State, counter, synchroniser and output registers; synchroniser runs even when disabled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q  <= '0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      KEY_OUT <= 1'b0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], KEY_IN};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      KEY_OUT <= key_d;
      PRESS   <= press_d;
      RELEASE <= release_d;
    end
  end

  // Next-state logic: qualify a candidate level over the full window, restart on any reversal.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    key_d     = KEY_OUT;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!EN) begin
      // Disabling drops the level silently, without a release event.
      state_d = IDLE_LO;
      key_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_d = IDLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE_HI;
            key_d   = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (s) begin
            state_d = IDLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE_LO;
            key_d     = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of N independent key debouncers with registered press/release events
// and a combined "any key down" flag.
module key_debounce_bank
  import key_debounce_bank_pkg::*;
#(
  parameter int unsigned N             = 8,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_SYN,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] KEYS_IN,
  input  logic [N-1:0] CH_EN,
  output logic [N-1:0] KEYS_OUT,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic         ANY_PRESSED
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .CLK     (CLK),
      .RESET   (RESET),
      .KEY_IN  (KEYS_IN[i]),
      .EN      (CH_EN[i]),
      .KEY_OUT (KEYS_OUT[i]),
      .PRESS   (PRESS[i]),
      .RELEASE (RELEASE[i])
    );
  end

  // Any committed key currently down.
  always_comb begin
    ANY_PRESSED = |KEYS_OUT;
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Self-checking bench for key_debounce_bank: directed scenarios plus random
// stimulus, all compared against a run-length reference model.
module tb_key_debounce_bank;

  localparam int unsigned N      = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [N-1:0] KEYS_IN;
  logic [N-1:0] CH_EN;
  logic [N-1:0] KEYS_OUT, PRESS, RELEASE;
  logic         ANY_PRESSED;

  key_debounce_bank #(
    .N             (N),
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .KEYS_IN     (KEYS_IN),
    .CH_EN       (CH_EN),
    .KEYS_OUT    (KEYS_OUT),
    .PRESS       (PRESS),
    .RELEASE     (RELEASE),
    .ANY_PRESSED (ANY_PRESSED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: input seen by the debouncer is the raw input delayed by
  // SYNC edges; a level flips once STABLE consecutive samples disagree with it.
  logic [N-1:0] dly [SYNC];
  logic [N-1:0] m_lvl, m_press, m_rel;
  int           m_run [N];

  task automatic model_edge();
    logic [N-1:0] smp;
    smp = dly[SYNC-1];
    m_press = '0;
    m_rel   = '0;
    if (RESET) begin
      for (int k = 0; k < SYNC; k++) dly[k] = '0;
      m_lvl = '0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
      return;
    end
    for (int k = SYNC - 1; k > 0; k--) dly[k] = dly[k-1];
    dly[0] = KEYS_IN;
    for (int c = 0; c < N; c++) begin
      if (!CH_EN[c]) begin
        m_lvl[c] = 1'b0;
        m_run[c] = 0;
      end else if (smp[c] == m_lvl[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] == STABLE) begin
          m_lvl[c] = smp[c];
          m_run[c] = 0;
          if (smp[c]) m_press[c] = 1'b1;
          else        m_rel[c]   = 1'b1;
        end
      end
    end
  endtask

  // One clock: advance model at the edge, compare outputs 1 time unit later.
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    cyc++;
    check("keys_out", 32'(KEYS_OUT), 32'(m_lvl));
    check("press",    32'(PRESS),    32'(m_press));
    check("release",  32'(RELEASE),  32'(m_rel));
    check("any",      32'(ANY_PRESSED), 32'(|m_lvl));
    check("excl",     32'(PRESS & RELEASE), 32'(0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    RESET   = 1'b1;
    KEYS_IN = 4'b1111;
    CH_EN   = 4'b1111;

    // Reset held with keys down: everything stays low.
    run(3);
    check("rst_keys", 32'(KEYS_OUT), 32'(0));
    check("rst_any",  32'(ANY_PRESSED), 32'(0));
    RESET = 1'b0;
    run(5);
    check("rst_rel_nopress", 32'(PRESS), 32'(0));
    run(1);
    check("rst_rel_press", 32'(PRESS), 32'hF);
    check("rst_rel_keys",  32'(KEYS_OUT), 32'hF);
    run(1);
    check("rst_rel_pulse1", 32'(PRESS), 32'(0));

    // Clean press / release on ch0.
    KEYS_IN = '0;
    run(10);
    KEYS_IN = 4'b0001;
    run(5);
    check("ch0_early", 32'(KEYS_OUT[0]), 32'(0));
    run(1);
    check("ch0_press", 32'(PRESS), 32'h1);
    check("ch0_keys",  32'(KEYS_OUT[0]), 32'(1));
    run(15);
    KEYS_IN = '0;
    run(5);
    check("ch0_rel_early", 32'(RELEASE), 32'(0));
    run(1);
    check("ch0_release", 32'(RELEASE), 32'h1);
    check("ch0_low",     32'(KEYS_OUT[0]), 32'(0));

    // Bounce on ch1 never commits; a steady level then does.
    run(4);
    KEYS_IN = 4'b0010; run(3);
    KEYS_IN = 4'b0000; run(1);
    KEYS_IN = 4'b0010; run(2);
    KEYS_IN = 4'b0000; run(8);
    check("bounce_keys", 32'(KEYS_OUT[1]), 32'(0));
    KEYS_IN = 4'b0010;
    run(5);
    check("bounce_nopress", 32'(PRESS[1]), 32'(0));
    run(1);
    check("bounce_press", 32'(PRESS[1]), 32'(1));

    // Simultaneous commits on ch2 / ch3.
    KEYS_IN = '0;
    run(10);
    KEYS_IN = 4'b1100;
    run(5);
    check("sim_any_lo", 32'(ANY_PRESSED), 32'(0));
    run(1);
    check("sim_press", 32'(PRESS), 32'hC);
    check("sim_any",   32'(ANY_PRESSED), 32'(1));
    KEYS_IN = 4'b1000;
    run(6);
    check("sim_rel2", 32'(RELEASE), 32'h4);
    check("sim_any_hold", 32'(ANY_PRESSED), 32'(1));
    KEYS_IN = 4'b0000;
    run(5);
    check("sim_any_hold2", 32'(ANY_PRESSED), 32'(1));
    run(1);
    check("sim_rel3", 32'(RELEASE), 32'h8);
    check("sim_any_off", 32'(ANY_PRESSED), 32'(0));

    // Enable dropped while committed, then restored with key held.
    KEYS_IN = 4'b0001;
    run(8);
    check("en_up", 32'(KEYS_OUT[0]), 32'(1));
    CH_EN = 4'b1110;
    run(1);
    check("en_off_keys", 32'(KEYS_OUT[0]), 32'(0));
    check("en_off_norel", 32'(RELEASE), 32'(0));
    run(3);
    CH_EN = 4'b1111;
    run(3);
    check("en_on_nopress", 32'(PRESS[0]), 32'(0));
    run(1);
    check("en_on_press", 32'(PRESS[0]), 32'(1));

    // Reset in the middle of a check aborts it.
    KEYS_IN = 4'b0011;
    run(4);
    RESET = 1'b1;
    run(1);
    check("midrst_nopress", 32'(PRESS), 32'(0));
    RESET = 1'b0;
    run(5);
    check("midrst_wait", 32'(PRESS[1]), 32'(0));
    run(1);
    check("midrst_press", 32'(PRESS[1]), 32'(1));

    // Random phase: sticky keys, occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(7) == 0) KEYS_IN[c] = ~KEYS_IN[c];
        CH_EN[c] = ($urandom_range(63) != 0);
      end
      RESET = ($urandom_range(299) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
